// File: rtl/chunked_subtractor_pkg.sv
// Shared definitions for the chunked subtractor: FSM encoding, default widths, op codes.
package chunked_subtractor_pkg;

  localparam int unsigned DATA_WIDTH  = 64;
  localparam int unsigned CHUNK_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

endpackage

// File: rtl/chunked_subtractor_adder.sv
// Combinational W-bit adder with carry-in/carry-out, shared across RUN cycles.
module chunk_adder #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  always_comb begin
    {cout, sum} = {1'b0, x} + {1'b0, y} + (W+1)'(cin);
  end

endmodule

// File: rtl/chunked_subtractor.sv
// Multi-cycle a - b over N/W clocks with zero and signed-overflow flags.
// Optional add mode (op port) enabled by CHUNKED_SUBTRACTOR_ADD_MODE_EN.
module chunked_subtractor
  import chunked_subtractor_pkg::*;
#(
  parameter int unsigned N = DATA_WIDTH,
  parameter int unsigned W = CHUNK_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
`ifdef CHUNKED_SUBTRACTOR_ADD_MODE_EN
  input  logic         op,
`endif
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         overflow
);

  localparam int unsigned NC = N / W;
  localparam int unsigned IW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NC - 1);

  generate
    if ((N % W) != 0) begin : g_bad_width
      $error("chunked_subtractor: N must be an integer multiple of W");
    end
  endgenerate

  state_t        state;
  logic [N-1:0]  a_q, b_q, work;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_chunk, b_chunk, b_eff, sum;
  logic          cout;
  logic          sign_diff;
`ifdef CHUNKED_SUBTRACTOR_ADD_MODE_EN
  logic          op_q;
`endif

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < NC; i++) begin
      if (idx == IW'(i)) begin
        a_chunk = a_q[i*W +: W];
        b_chunk = b_q[i*W +: W];
      end
    end
  end

`ifdef CHUNKED_SUBTRACTOR_ADD_MODE_EN
  assign b_eff = (op_q == OP_ADD) ? b_chunk : ~b_chunk;
`else
  assign b_eff = ~b_chunk;
`endif

  assign sign_diff = a_q[N-1] ^ b_q[N-1];

  chunk_adder #(.W(W)) u_chunk_adder (
    .x   (a_chunk),
    .y   (b_eff),
    .cin (carry),
    .sum (sum),
    .cout(cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work     <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
`ifdef CHUNKED_SUBTRACTOR_ADD_MODE_EN
      op_q     <= OP_SUB;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef CHUNKED_SUBTRACTOR_ADD_MODE_EN
            op_q  <= op;
            carry <= (op == OP_SUB);
`else
            carry <= 1'b1;
`endif
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NC; i++) begin
            if (idx == IW'(i)) work[i*W +: W] <= sum;
          end
          carry <= cout;
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          result <= work;
          zero   <= ~|work;
          done   <= 1'b1;
          state  <= IDLE;
`ifdef CHUNKED_SUBTRACTOR_ADD_MODE_EN
          // Operand signs must differ for sub overflow, match for add overflow.
          overflow <= ((op_q == OP_ADD) ? ~sign_diff : sign_diff) && (work[N-1] != a_q[N-1]);
`else
          overflow <= sign_diff && (work[N-1] != a_q[N-1]);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_subtractor.sv
// Scoreboard bench for chunked_subtractor at default widths (N=64, W=16).
module tb_chunked_subtractor;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [63:0] a, b;
  logic        busy, done, zero, overflow;
  logic [63:0] result;

  typedef struct packed {
    logic [63:0] r;
    logic        z;
    logic        v;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] prev_result = '0;

  always #5 clk = ~clk;

  chunked_subtractor #(.N(64), .W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
`ifdef CHUNKED_SUBTRACTOR_ADD_MODE_EN
    .op      (op),
`endif
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .zero    (zero),
    .overflow(overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y);
    exp_t e;
    e.r = x - y;
    e.z = (e.r == 64'd0);
    e.v = (x[63] != y[63]) && (e.r[63] != x[63]);
    return e;
  endfunction

  // Runs one operation; optionally pokes start and a during RUN to show they are ignored.
  task automatic run_op(input string tag, input logic [63:0] x, input logic [63:0] y, input bit poke);
    int   cyc;
    int   busy_cnt;
    exp_t e;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    sb.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_cnt = int'(busy);
    while (!done && cyc < 20) begin
      if (poke && cyc == 2) begin start = 1'b1; a = $urandom; end
      if (poke && cyc == 3) start = 1'b0;
      if (cyc == 2) check({tag, "_hold"}, result, prev_result);
      @(negedge clk);
      cyc++;
      busy_cnt += int'(busy);
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'd6);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd4);
    e = sb.pop_front();
    check({tag, "_result"}, result, e.r);
    check({tag, "_zero"}, 64'(zero), 64'(e.z));
    check({tag, "_overflow"}, 64'(overflow), 64'(e.v));
    prev_result = e.r;
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; op = 1'b0; a = 64'd9; b = 64'd2;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    start = 1'b0;
    reset = 1'b0;

    run_op("basic", 64'd10, 64'd3, 1'b0);
    run_op("equal", 64'd5, 64'd5, 1'b0);
    run_op("negative", 64'd3, 64'd10, 1'b0);
    check("negative_const", result, 64'hFFFF_FFFF_FFFF_FFF9);
    run_op("ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0);
    check("ovf_const", result, 64'h7FFF_FFFF_FFFF_FFFF);
    run_op("borrow", 64'h0000_0000_0001_0000, 64'd1, 1'b1);
    check("borrow_const", result, 64'h0000_0000_0000_FFFF);
    run_op("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    for (int i = 0; i < 4; i++)
      run_op("rand", {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);

    // Abort in the 2nd RUN cycle: outputs return to reset values next cycle.
    @(negedge clk);
    a = 64'h1234; b = 64'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_zero", 64'(zero), 64'd0);
    check("abort_overflow", 64'(overflow), 64'd0);
    reset = 1'b0;
    prev_result = '0;
    run_op("after_abort", 64'd1, 64'd2, 1'b0);
    check("after_abort_const", result, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
